// File: rtl/demux_feeder_16_3.sv
`default_nettype none
// ============================================================================
//  Module   : demux_feeder_16_3
//  Purpose  : Upstream sequencer for a 4-way demultiplexer stage. Accepts
//             (data, channel) words over valid/ready, queues them in a small
//             FIFO and presents each word on the demux D/S inputs for exactly
//             HOLD cycles, with out_valid marking when D/S carry a live word.
//  Ports    : clk, rst_n       - clock, asynchronous active-low reset
//             in_valid/in_ready/in_data/in_sel - upstream handshake + word
//             D, S             - registered demux data / select
//             out_valid        - D/S carry a live word
//             count            - queued words, excluding the one on D/S
//             busy             - out_valid | (count != 0)
//  Revision : 1.0 - initial release
// ============================================================================
module demux_feeder_16_3 #(
   parameter int DW    = 3,
   parameter int DEPTH = 4,
   parameter int HOLD  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DW-1:0]              in_data,
   input  logic [1:0]                 in_sel,
   output logic [DW-1:0]              D,
   output logic [1:0]                 S,
   output logic                       out_valid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy
);

   localparam int c_CW = $clog2(DEPTH + 1);
   localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [c_HW-1:0]   r_hold, w_hold_nxt;
   logic [DW-1:0]     r_d, w_d_nxt;
   logic [1:0]        r_s, w_s_nxt;
   logic              r_ov, w_ov_nxt;

   logic [DW+1:0]     r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [c_CW-1:0]   r_count;
   logic [DW+1:0]     w_head;
   logic              w_push, w_pop;

   // Ready depends only on the registered count, so a full FIFO refuses a
   // push even on an edge that also pops.
   assign in_ready = (r_count < c_CW'(DEPTH));
   assign w_push   = in_valid & in_ready;
   assign w_head   = r_mem[r_rd_ptr];

   // ------------------------------------------------------------------
   // FIFO storage: contents need no reset, the pointers define validity.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_sel, in_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the wrap.
         if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sequencer: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_d     <= '0;
         r_s     <= '0;
         r_ov    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_d     <= w_d_nxt;
         r_s     <= w_s_nxt;
         r_ov    <= w_ov_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer: next state / next outputs. D/S keep their last value when
   // idle so the downstream demux never sees a spurious routing change.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_d_nxt     = r_d;
      w_s_nxt     = r_s;
      w_ov_nxt    = r_ov;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
            w_ov_nxt = 1'b0;
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_d_nxt     = w_head[DW-1:0];
               w_s_nxt     = w_head[DW+1:DW];
               w_ov_nxt    = 1'b1;
               w_hold_nxt  = c_HOLD_LAST;
               w_state_nxt = DRIVE;
            end
         end
         DRIVE: begin
            if (r_hold != '0) begin
               w_hold_nxt = r_hold - c_HW'(1);
            end else if (r_count != '0) begin
               // Back-to-back: next word replaces the current one with no gap.
               w_pop      = 1'b1;
               w_d_nxt    = w_head[DW-1:0];
               w_s_nxt    = w_head[DW+1:DW];
               w_hold_nxt = c_HOLD_LAST;
            end else begin
               w_ov_nxt    = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_ov_nxt    = 1'b0;
         end
      endcase
   end

   assign D         = r_d;
   assign S         = r_s;
   assign out_valid = r_ov;
   assign count     = r_count;
   assign busy      = r_ov | (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_demux_feeder_16_3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_feeder_16_3
//  Purpose  : Scoreboard bench for demux_feeder_16_3. One instance with
//             HOLD=4 and one with HOLD=1 (both DEPTH=4, DW=3). Accepted words
//             are queued; per-instance monitors pop and compare each word as
//             it appears on D/S and check it stays stable for HOLD cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_feeder_16_3;

   localparam int c_H4 = 4;

   logic       clk;
   logic       rst_n;

   // HOLD=4 instance
   logic       v4;
   logic [2:0] d4;
   logic [1:0] s4;
   logic       rdy4, ov4, busy4;
   logic [2:0] D4;
   logic [1:0] S4;
   logic [2:0] cnt4;

   // HOLD=1 instance
   logic       v1;
   logic [2:0] d1;
   logic [1:0] s1;
   logic       rdy1, ov1, busy1;
   logic [2:0] D1;
   logic [1:0] S1;
   logic [2:0] cnt1;

   int checks = 0;
   int errors = 0;

   logic [4:0] q4[$];
   logic [4:0] q1[$];

   demux_feeder_16_3 #(.DW(3), .DEPTH(4), .HOLD(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_sel(s4),
      .D(D4), .S(S4), .out_valid(ov4), .count(cnt4), .busy(busy4)
   );

   demux_feeder_16_3 #(.DW(3), .DEPTH(4), .HOLD(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v1), .in_ready(rdy1), .in_data(d1), .in_sel(s1),
      .D(D1), .S(S1), .out_valid(ov1), .count(cnt1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard input side: record every word the DUT accepts.
   always @(posedge clk) begin
      if (rst_n && v4 && rdy4) q4.push_back({s4, d4});
      if (rst_n && v1 && rdy1) q1.push_back({s1, d1});
   end

   // Monitor, HOLD=4 instance
   int         ph4 = 0;
   logic [4:0] cur4 = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         ph4 = 0;
      end else if (ov4) begin
         if (ph4 == 0) begin
            if (q4.size() == 0) begin
               checks++; errors++;
               $display("FAIL word4 unexpected actual=%0h required=none t=%0t", {S4, D4}, $time);
            end else begin
               cur4 = q4.pop_front();
               check("word4", {S4, D4}, cur4);
            end
         end else begin
            check("hold4", {S4, D4}, cur4);
         end
         ph4 = (ph4 + 1) % c_H4;
      end else begin
         if (ph4 != 0) begin
            checks++; errors++;
            $display("FAIL short4 actual=%0d required=%0d t=%0t", ph4, c_H4, $time);
         end
         ph4 = 0;
      end
   end

   // Monitor, HOLD=1 instance: every valid cycle is a new word.
   always @(negedge clk) begin
      if (rst_n && ov1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL word1 unexpected actual=%0h required=none t=%0t", {S1, D1}, $time);
         end else begin
            check("word1", {S1, D1}, q1.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_D"},     D4,    0);
      check({tag, "_S"},     S4,    0);
      check({tag, "_ov"},    ov4,   0);
      check({tag, "_cnt"},   cnt4,  0);
      check({tag, "_rdy"},   rdy4,  1);
      check({tag, "_busy"},  busy4, 0);
   endtask

   int         idx, refusals, first_refuse, first_low, ov_cnt;
   logic       r;
   logic       ov_log [12];
   logic [2:0] d_log  [12];

   initial begin
      rst_n = 1'b1;
      v4 = 0; d4 = 0; s4 = 0;
      v1 = 0; d1 = 0; s1 = 0;

      // ---------------- reset: async clear before any edge -------------
      #1 rst_n = 1'b0;
      #1;
      check_reset_state("rst");
      check("rst_ov1", ov1, 0);
      check("rst_cnt1", cnt1, 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // ---------------- single word, HOLD=4 ----------------------------
      @(negedge clk); v4 = 1; d4 = 3'b111; s4 = 2'b00;
      @(negedge clk); v4 = 0;                       // after edge 0
      check("single_cnt_e0", cnt4, 1);
      check("single_ov_e0", ov4, 0);
      @(negedge clk);                               // after edge 1
      check("single_ov_e1", ov4, 1);
      check("single_D_e1", D4, 3'b111);
      check("single_S_e1", S4, 2'b00);
      repeat (3) @(negedge clk);                    // after edge 4
      check("single_ov_e4", ov4, 1);
      @(negedge clk);                               // after edge 5
      check("single_ov_e5", ov4, 0);
      check("single_D_e5", D4, 3'b111);
      check("single_S_e5", S4, 2'b00);
      check("single_busy_e5", busy4, 0);

      // ---------------- select sweep -----------------------------------
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         v4 = 1; d4 = 3'b111; s4 = i[1:0];
         @(negedge clk);
      end
      v4 = 0;                                       // after edge 3
      check("sweep_cnt_peak", cnt4, 3);
      check("sweep_ov_e3", ov4, 1);
      first_low = -1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);                            // after edge 4+k
         if (!ov4 && first_low < 0) first_low = k;
      end
      check("sweep_first_idle", first_low, 13);
      check("sweep_busy_end", busy4, 0);

      // ---------------- backpressure -----------------------------------
      idx = 0; refusals = 0; first_refuse = -1;
      for (int g = 0; g < 40 && idx < 6; g++) begin
         @(negedge clk);
         v4 = 1; d4 = idx[2:0]; s4 = idx[1:0];
         r = rdy4;
         if (!r) begin
            refusals++;
            if (first_refuse < 0) first_refuse = idx;
            check("bp_full_cnt", cnt4, 4);
         end
         @(posedge clk);
         if (r) idx++;
      end
      @(negedge clk); v4 = 0;
      check("bp_all_sent", idx, 6);
      check("bp_refusals", refusals, 1);
      check("bp_first_refused", first_refuse, 5);
      repeat (30) @(negedge clk);
      check("bp_busy_end", busy4, 0);

      // ---------------- reset mid-operation ----------------------------
      @(negedge clk); v4 = 1; d4 = 3'd5; s4 = 2'd1;
      @(negedge clk);         d4 = 3'd6; s4 = 2'd2;
      @(negedge clk);         d4 = 3'd4; s4 = 2'd3;
      @(negedge clk); v4 = 0;                       // after edge 2
      check("mid_cnt", cnt4, 2);
      check("mid_ov", ov4, 1);
      check("mid_D", D4, 3'd5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_state("midrst");
      q4.delete();
      #4 rst_n = 1'b1;
      @(negedge clk); v4 = 1; d4 = 3'b010; s4 = 2'b11;
      @(negedge clk); v4 = 0;
      check("post_cnt", cnt4, 1);
      check("post_ov0", ov4, 0);
      @(negedge clk);
      check("post_ov1", ov4, 1);
      check("post_D", D4, 3'b010);
      check("post_S", S4, 2'b11);
      repeat (8) @(negedge clk);
      check("post_busy_end", busy4, 0);

      // ---------------- streaming, HOLD=1 ------------------------------
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         ov_log[n] = ov1;
         d_log[n]  = D1;
         if (n < 8) begin
            check("stream_rdy", rdy1, 1);
            v1 = 1; d1 = n[2:0]; s1 = n[1:0];
         end else begin
            v1 = 0;
         end
      end
      ov_cnt = 0;
      for (int n = 0; n < 12; n++) begin
         check("stream_ov", ov_log[n], (n >= 2 && n <= 9) ? 1 : 0);
         if (ov_log[n]) ov_cnt++;
      end
      for (int n = 2; n <= 9; n++) begin
         check("stream_D", d_log[n], n - 2);
      end
      check("stream_ov_cycles", ov_cnt, 8);
      check("stream_busy_end", busy1, 0);

      // ---------------- scoreboard drained -----------------------------
      repeat (2) @(negedge clk);
      check("q4_empty", q4.size(), 0);
      check("q1_empty", q1.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
